// File: rtl/arith_mac_pipe.sv
// Two-stage pipelined MW x MW multiply-accumulate with a DW+GUARD bit accumulator,
// raw/saturating/guard-bit readout, sticky wrap flag and valid/ready flow control.
module arith_mac_pipe #(
  parameter int DW    = 32,
  parameter int MW    = 16,
  parameter int GUARD = 8
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic          cmd_sign,
  input  logic [MW-1:0] cmd_a,
  input  logic [MW-1:0] cmd_b,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_zero,
  output logic          res_neg,
  output logic          res_sat,
  output logic          acc_ovf
);
  localparam int AW = DW + GUARD;
  localparam int PW = 2 * MW;

  typedef enum logic [2:0] {
    OP_MUL   = 3'b000,
    OP_MACI  = 3'b001,
    OP_MAC   = 3'b010,
    OP_MSU   = 3'b011,
    OP_RDACC = 3'b100,
    OP_RDSAT = 3'b101,
    OP_RDTOP = 3'b110,
    OP_CLR   = 3'b111
  } op_e;

  function automatic logic signed [AW-1:0] extend_prod(input logic [PW-1:0] p, input logic sgn);
    return {{(AW-PW){sgn & p[PW-1]}}, p};
  endfunction

  // Returns {signed-overflow, wrapped result}.
  function automatic logic [AW:0] acc_addsub(input logic signed [AW-1:0] lhs,
                                             input logic signed [AW-1:0] rhs,
                                             input logic sub);
    logic signed [AW-1:0] res;
    logic                 ovf;
    if (sub) begin
      res = lhs - rhs;
      ovf = (lhs[AW-1] != rhs[AW-1]) && (res[AW-1] != lhs[AW-1]);
    end else begin
      res = lhs + rhs;
      ovf = (lhs[AW-1] == rhs[AW-1]) && (res[AW-1] != lhs[AW-1]);
    end
    return {ovf, res};
  endfunction

  // Returns {clamped, value}; in range when every bit above DW-2 matches the sign.
  function automatic logic [DW:0] sat_dw(input logic signed [AW-1:0] v);
    logic [DW:0] r;
    if (v[AW-1:DW-1] == {(AW-DW+1){v[AW-1]}})
      r = {1'b0, v[DW-1:0]};
    else if (v[AW-1])
      r = {1'b1, 1'b1, {(DW-1){1'b0}}};
    else
      r = {1'b1, 1'b0, {(DW-1){1'b1}}};
    return r;
  endfunction

  logic adv;
  assign adv       = ~res_valid | res_ready;
  assign cmd_ready = adv;

  // Stage 0 -> 1: operand extension and product
  logic [PW-1:0] a_ext, b_ext, prod;
  assign a_ext = {{MW{cmd_sign & cmd_a[MW-1]}}, cmd_a};
  assign b_ext = {{MW{cmd_sign & cmd_b[MW-1]}}, cmd_b};
  assign prod  = a_ext * b_ext;

  logic          vld_p1;
  op_e           op_p1;
  logic          sign_p1;
  logic [PW-1:0] prod_p1;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      op_p1   <= OP_MUL;
      sign_p1 <= 1'b0;
      prod_p1 <= '0;
    end else if (adv) begin
      vld_p1 <= cmd_valid;
      if (cmd_valid) begin
        op_p1   <= op_e'(cmd_op);
        sign_p1 <= cmd_sign;
        prod_p1 <= prod;
      end
    end
  end

  // Stage 1 -> 2: op execution against the accumulator
  logic signed [AW-1:0] pext_p1;
  logic signed [AW-1:0] acc_p2;
  logic signed [AW-1:0] acc_next;
  logic [AW:0]          addsub;
  logic [DW:0]          sat;
  logic [DW-1:0]        data_next;
  logic                 sat_next;
  logic                 ovf_next;

  assign pext_p1 = extend_prod(prod_p1, sign_p1);
  assign addsub  = acc_addsub(acc_p2, pext_p1, op_p1 == OP_MSU);
  assign sat     = sat_dw(acc_p2);

  always_comb begin
    acc_next  = acc_p2;
    ovf_next  = acc_ovf;
    data_next = '0;
    sat_next  = 1'b0;
    case (op_p1)
      OP_MUL:   data_next = pext_p1[DW-1:0];
      OP_MACI: begin
        acc_next  = pext_p1;
        ovf_next  = 1'b0;
        data_next = pext_p1[DW-1:0];
      end
      OP_MAC, OP_MSU: begin
        acc_next  = addsub[AW-1:0];
        ovf_next  = acc_ovf | addsub[AW];
        data_next = addsub[DW-1:0];
      end
      OP_RDACC: data_next = acc_p2[DW-1:0];
      OP_RDSAT: begin
        data_next = sat[DW-1:0];
        sat_next  = sat[DW];
      end
      OP_RDTOP: data_next = {{(DW-GUARD){acc_p2[AW-1]}}, acc_p2[AW-1:DW]};
      OP_CLR: begin
        acc_next = '0;
        ovf_next = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b1;
      res_neg   <= 1'b0;
      res_sat   <= 1'b0;
      acc_ovf   <= 1'b0;
      acc_p2    <= '0;
    end else if (adv) begin
      res_valid <= vld_p1;
      if (vld_p1) begin
        acc_p2   <= acc_next;
        acc_ovf  <= ovf_next;
        res_data <= data_next;
        res_zero <= (data_next == '0);
        res_neg  <= data_next[DW-1];
        res_sat  <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_arith_mac_pipe.sv
// Self-checking bench for arith_mac_pipe: exact-integer accumulator model, directed
// scenarios and randomized traffic with random consumer backpressure.
module tb_arith_mac_pipe;
  localparam logic [2:0] MUL = 3'd0, MACI = 3'd1, MAC = 3'd2, MSU = 3'd3,
                         RDACC = 3'd4, RDSAT = 3'd5, RDTOP = 3'd6, CLR = 3'd7;
  localparam longint AMAX = 64'sd549755813887;   // 2^39 - 1
  localparam longint AMIN = -64'sd549755813888;  // -2^39
  localparam longint AMOD = 64'sd1099511627776;  // 2^40

  typedef struct packed {
    logic [31:0] data;
    logic        zero;
    logic        neg;
    logic        sat;
    logic        ovf;
  } res_t;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_sign = 1'b0;
  logic        res_ready = 1'b1;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_a = 16'd0;
  logic [15:0] cmd_b = 16'd0;
  logic        cmd_ready, res_valid, res_zero, res_neg, res_sat, acc_ovf;
  logic [31:0] res_data;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_ready = 0;

  res_t   obs_q[$];
  int     obs_cyc[$];
  res_t   exp_q[$];
  int     acc_cyc[$];
  longint m_acc = 0;
  bit     m_ovf = 0;

  arith_mac_pipe #(.DW(32), .MW(16), .GUARD(8)) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_sign (cmd_sign),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_zero (res_zero),
    .res_neg  (res_neg),
    .res_sat  (res_sat),
    .acc_ovf  (acc_ovf)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(posedge sys_clk) begin
    if (!reset && res_valid && res_ready) begin
      obs_q.push_back(res_t'({res_data, res_zero, res_neg, res_sat, acc_ovf}));
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Accumulator held as an exact integer; wrap and overflow come from range checks.
  function automatic res_t model(input logic [2:0] op, input logic sgn, input logic [15:0] a, input logic [15:0] b);
    longint p, t;
    res_t   r;
    r = '0;
    p = sgn ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
    case (op)
      MUL:  r.data = p[31:0];
      MACI: begin m_acc = p; m_ovf = 0; r.data = p[31:0]; end
      MAC, MSU: begin
        t = (op == MAC) ? m_acc + p : m_acc - p;
        if (t > AMAX) begin t = t - AMOD; m_ovf = 1; end
        else if (t < AMIN) begin t = t + AMOD; m_ovf = 1; end
        m_acc = t;
        r.data = t[31:0];
      end
      RDACC: r.data = m_acc[31:0];
      RDSAT: begin
        if (m_acc > 64'sd2147483647) begin r.data = 32'h7FFFFFFF; r.sat = 1'b1; end
        else if (m_acc < -64'sd2147483648) begin r.data = 32'h80000000; r.sat = 1'b1; end
        else r.data = m_acc[31:0];
      end
      RDTOP: begin t = m_acc >>> 32; r.data = t[31:0]; end
      default: begin m_acc = 0; m_ovf = 0; r.data = 32'h0; end
    endcase
    r.zero = (r.data == 32'h0);
    r.neg  = r.data[31];
    r.ovf  = m_ovf;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [2:0] op, input logic sgn, input logic [15:0] a, input logic [15:0] b);
    int waited = 0;
    exp_q.push_back(model(op, sgn, a, b));
    cmd_op = op; cmd_sign = sgn; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    forever begin
      if (rand_ready) res_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (cmd_ready) break;
      if (waited++ > 500) begin
        checks++; errors++;
        $display("FAIL send_timeout op %0d cmd_ready %b required 1", op, cmd_ready);
        cmd_valid = 1'b0;
        return;
      end
      @(negedge sys_clk);
    end
    acc_cyc.push_back(cyc);
    @(posedge sys_clk);
    @(negedge sys_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    cmd_valid = 1'b0; rand_ready = 0; res_ready = 1'b1;
    while (obs_q.size() < exp_q.size() && w < 3000) begin @(negedge sys_clk); w++; end
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic clear();
    obs_q.delete(); obs_cyc.delete(); exp_q.delete(); acc_cyc.delete();
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
    checks++; if (res_data !== 32'h0) begin errors++; $display("FAIL rst_res_data got %h exp 0", res_data); end
    checks++; if ({res_zero, res_neg, res_sat, acc_ovf} !== 4'b1000)
      begin errors++; $display("FAIL rst_flags got %b exp 1000", {res_zero, res_neg, res_sat, acc_ovf}); end
    @(negedge sys_clk); reset = 1'b0;
    m_acc = 0; m_ovf = 0;
    send(MACI, 1'b1, 16'hFFFB, 16'd7);
    send(MAC, 1'b1, 16'd1234, 16'd99);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL rst_midstream_valid got %b exp 1", res_valid); end
    reset = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b exp 0", res_valid); end
    checks++; if (acc_ovf !== 1'b0) begin errors++; $display("FAIL rst_async_ovf got %b exp 0", acc_ovf); end
    @(negedge sys_clk); reset = 1'b0;
    clear(); m_acc = 0; m_ovf = 0;
    send(RDACC, 1'b0, 16'd0, 16'd0);
    drain();
    checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL rst_count got %0d exp 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL rst_rdacc got %h exp %h", obs_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_mac_chain();
    clear();
    send(MACI, 1'b1, 16'hFFFD, 16'd4);
    send(MAC, 1'b1, 16'd100, 16'd2);
    send(MSU, 1'b1, 16'd1, 16'd1);
    drain();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL chain_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL chain_res[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
      checks++; if (obs_cyc[i] - acc_cyc[i] !== 2)
        begin errors++; $display("FAIL chain_latency[%0d] got %0d exp 2", i, obs_cyc[i] - acc_cyc[i]); end
      if (i > 0) begin
        checks++; if (acc_cyc[i] - acc_cyc[i-1] !== 1)
          begin errors++; $display("FAIL chain_issue_gap[%0d] got %0d exp 1", i, acc_cyc[i] - acc_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_sign_mul();
    clear();
    send(MUL, 1'b0, 16'hFFFF, 16'hFFFF);
    send(MUL, 1'b1, 16'hFFFF, 16'hFFFF);
    send(MUL, 1'b1, 16'h8000, 16'h7FFF);
    send(MUL, 1'b0, 16'h8000, 16'h0002);
    drain();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL mul_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL mul_res[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() >= 2) begin
      checks++; if ({obs_q[0].data, obs_q[0].neg} !== {32'hFFFE0001, 1'b1})
        begin errors++; $display("FAIL mul_unsigned got %h/%b exp fffe0001/1", obs_q[0].data, obs_q[0].neg); end
      checks++; if ({obs_q[1].data, obs_q[1].neg} !== {32'h00000001, 1'b0})
        begin errors++; $display("FAIL mul_signed got %h/%b exp 00000001/0", obs_q[1].data, obs_q[1].neg); end
    end
  endtask

  task automatic test_saturation();
    clear();
    send(CLR, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 300; i++) send(MAC, 1'b1, 16'h7FFF, 16'h7FFF);
    send(RDSAT, 1'b0, 16'd0, 16'd0);
    send(RDTOP, 1'b0, 16'd0, 16'd0);
    send(RDACC, 1'b0, 16'd0, 16'd0);
    send(CLR, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 300; i++) send(MSU, 1'b1, 16'h7FFF, 16'h7FFF);
    send(RDSAT, 1'b0, 16'd0, 16'd0);
    send(RDTOP, 1'b0, 16'd0, 16'd0);
    drain();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL sat_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL sat_res[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() >= 607) begin
      checks++; if ({obs_q[301].data, obs_q[301].sat} !== {32'h7FFFFFFF, 1'b1})
        begin errors++; $display("FAIL sat_pos got %h/%b exp 7fffffff/1", obs_q[301].data, obs_q[301].sat); end
      checks++; if (obs_q[302].data !== 32'h0000004A)
        begin errors++; $display("FAIL sat_rdtop got %h exp 0000004a", obs_q[302].data); end
      checks++; if ({obs_q[303].sat, obs_q[303].ovf} !== 2'b00)
        begin errors++; $display("FAIL sat_rdacc_flags got %b exp 00", {obs_q[303].sat, obs_q[303].ovf}); end
      checks++; if ({obs_q[605].data, obs_q[605].sat} !== {32'h80000000, 1'b1})
        begin errors++; $display("FAIL sat_neg got %h/%b exp 80000000/1", obs_q[605].data, obs_q[605].sat); end
      checks++; if (obs_q[606].data !== 32'hFFFFFFB5)
        begin errors++; $display("FAIL sat_rdtop_neg got %h exp ffffffb5", obs_q[606].data); end
    end
  endtask

  task automatic test_overflow();
    clear();
    send(MACI, 1'b1, 16'h8000, 16'h8000);
    for (int i = 0; i < 520; i++) send(MAC, 1'b1, 16'h8000, 16'h8000);
    send(RDACC, 1'b0, 16'd0, 16'd0);
    send(CLR, 1'b0, 16'd0, 16'd0);
    drain();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_res[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() >= 523) begin
      // 511 * 2^30 still fits in 40 signed bits; 512 * 2^30 does not.
      checks++; if (obs_q[510].ovf !== 1'b0) begin errors++; $display("FAIL ovf_before_wrap got %b exp 0", obs_q[510].ovf); end
      checks++; if (obs_q[511].ovf !== 1'b1) begin errors++; $display("FAIL ovf_at_wrap got %b exp 1", obs_q[511].ovf); end
      checks++; if (obs_q[521].ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", obs_q[521].ovf); end
      checks++; if ({obs_q[522].ovf, obs_q[522].zero} !== 2'b01)
        begin errors++; $display("FAIL ovf_clr got ovf %b zero %b exp ovf 0 zero 1", obs_q[522].ovf, obs_q[522].zero); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    clear();
    rand_ready = 0;
    res_ready = 1'b0;
    fork
      begin
        send(MAC, 1'b1, 16'd300, 16'hFFF0);
        send(MSU, 1'b0, 16'hABCD, 16'd17);
        send(MAC, 1'b1, 16'h1234, 16'h0101);
        send(RDACC, 1'b0, 16'd0, 16'd0);
      end
      begin
        repeat (2) @(negedge sys_clk);
        held = res_data;
        for (int i = 0; i < 5; i++) begin
          checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready[%0d] got %b exp 0", i, cmd_ready); end
          checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_res_valid[%0d] got %b exp 1", i, res_valid); end
          checks++; if (res_data !== held) begin errors++; $display("FAIL bp_res_stable[%0d] got %h exp %h", i, res_data, held); end
          @(negedge sys_clk);
        end
        res_ready = 1'b1;
      end
    join
    drain();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_res[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic        sgn;
    logic [15:0] a, b;
    clear();
    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      op  = 3'($urandom_range(0, 7));
      sgn = 1'($urandom_range(0, 1));
      a   = 16'($urandom);
      b   = 16'($urandom);
      send(op, sgn, a, b);
      if ($urandom_range(0, 5) == 0) @(negedge sys_clk);
    end
    drain();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_res[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_mac_chain();
    test_sign_mul();
    test_saturation();
    test_overflow();
    test_backpressure();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
